// File: rtl/signext_pkg.sv
// signext_pkg: opcode constants, immediate field positions, format enum and
// sign-extension helpers shared by the LEGv8 immediate extender.
// Optional feature macro: SIGNEXT_B_FORMAT_EN (B-type decode).
package signext_pkg;

  localparam int INSTR_W  = 32;
  localparam int RESULT_W = 64;

  // Opcode constants; each is compared against the top bits of the
  // instruction, so every constant carries its own width.
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Immediate field positions within the 32-bit instruction word.
  localparam int CB_IMM_MSB = 23;
  localparam int CB_IMM_LSB = 5;
  localparam int D_IMM_MSB  = 20;
  localparam int D_IMM_LSB  = 12;
  localparam int I_IMM_MSB  = 21;
  localparam int I_IMM_LSB  = 10;
  localparam int B_IMM_MSB  = 25;
  localparam int B_IMM_LSB  = 0;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_CB   = 3'd1,
    FMT_D    = 3'd2,
    FMT_I    = 3'd3,
    FMT_B    = 3'd4
  } imm_fmt_e;

  // Opcode matchers. They look only at the opcode bits of each format.
  function automatic logic is_cb_op(input logic [INSTR_W-1:0] instr);
    return (instr[31:24] == OP_CBZ) || (instr[31:24] == OP_CBNZ);
  endfunction

  function automatic logic is_d_op(input logic [INSTR_W-1:0] instr);
    return (instr[31:21] == OP_LDUR) || (instr[31:21] == OP_STUR);
  endfunction

  function automatic logic is_i_op(input logic [INSTR_W-1:0] instr);
    return (instr[31:22] == OP_ADDI);
  endfunction

  function automatic logic is_b_op(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_B);
  endfunction

  // Sign-extension helpers: replicate the field MSB up to 64 bits.
  // Branch offsets stay in instruction units; the <<2 happens downstream.
  function automatic logic [RESULT_W-1:0] sext_cb(input logic [INSTR_W-1:0] instr);
    return {{45{instr[CB_IMM_MSB]}}, instr[CB_IMM_MSB:CB_IMM_LSB]};
  endfunction

  function automatic logic [RESULT_W-1:0] sext_d(input logic [INSTR_W-1:0] instr);
    return {{55{instr[D_IMM_MSB]}}, instr[D_IMM_MSB:D_IMM_LSB]};
  endfunction

  // ADDI immediate is deliberately sign-extended, not zero-extended.
  function automatic logic [RESULT_W-1:0] sext_i(input logic [INSTR_W-1:0] instr);
    return {{52{instr[I_IMM_MSB]}}, instr[I_IMM_MSB:I_IMM_LSB]};
  endfunction

  function automatic logic [RESULT_W-1:0] sext_b(input logic [INSTR_W-1:0] instr);
    return {{38{instr[B_IMM_MSB]}}, instr[B_IMM_MSB:B_IMM_LSB]};
  endfunction

endpackage

// File: rtl/signext_reg_imm_decode.sv
// imm_decode: purely combinational opcode decode and immediate sign-extension.
// Optional feature macro: SIGNEXT_B_FORMAT_EN adds B-type decode; without it
// the B opcode falls through to FMT_NONE like any unrecognised opcode.
module imm_decode
  import signext_pkg::*;
(
  input  logic [INSTR_W-1:0]  instruction,
  output imm_fmt_e            fmt,
  output logic [RESULT_W-1:0] ext_value
);

  imm_fmt_e             w_fmt;
  logic [RESULT_W-1:0]  w_ext;
  logic                 w_unused_bits;

  // Rt/Rd bits never feed any immediate; fold them so they are visibly unused.
  assign w_unused_bits = ^instruction[4:0];

  // Classify the opcode; patterns are mutually exclusive so order is irrelevant.
  always_comb begin
    w_fmt = FMT_NONE;
    if (is_cb_op(instruction)) begin
      w_fmt = FMT_CB;
    end else if (is_d_op(instruction)) begin
      w_fmt = FMT_D;
    end else if (is_i_op(instruction)) begin
      w_fmt = FMT_I;
`ifdef SIGNEXT_B_FORMAT_EN
    end else if (is_b_op(instruction)) begin
      w_fmt = FMT_B;
`endif
    end else begin
      w_fmt = FMT_NONE;
    end
  end

  // Select and sign-extend the field belonging to the decoded format.
  always_comb begin
    w_ext = 64'h0;
    case (w_fmt)
      FMT_CB:   w_ext = sext_cb(instruction);
      FMT_D:    w_ext = sext_d(instruction);
      FMT_I:    w_ext = sext_i(instruction);
`ifdef SIGNEXT_B_FORMAT_EN
      FMT_B:    w_ext = sext_b(instruction);
`endif
      FMT_NONE: w_ext = 64'h0;
      default:  w_ext = 64'h0;
    endcase
  end

  assign fmt       = w_fmt;
  assign ext_value = w_ext;

endmodule

// File: rtl/signext_reg.sv
// signext_reg: LEGv8 immediate sign-extender with a single output register.
// The instruction sampled on edge N appears on result/imm_valid after edge N.
// Optional feature macro: SIGNEXT_B_FORMAT_EN (B-type decode, in imm_decode).
module signext_reg
  import signext_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [RESULT_W-1:0] result,
  output logic                imm_valid
);

  imm_fmt_e             w_fmt;
  logic [RESULT_W-1:0]  w_ext;
  logic                 w_valid;
  logic [RESULT_W-1:0]  r_result;
  logic                 r_imm_valid;

  imm_decode u_imm_decode (
    .instruction (instruction),
    .fmt         (w_fmt),
    .ext_value   (w_ext)
  );

  assign w_valid = (w_fmt != FMT_NONE);

  // Output register; reset wins over decode and clears on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result    <= 64'h0;
      r_imm_valid <= 1'b0;
    end else begin
      r_result    <= w_ext;
      r_imm_valid <= w_valid;
    end
  end

  assign result    = r_result;
  assign imm_valid = r_imm_valid;

endmodule

// File: tb/tb_signext_reg.sv
// tb_signext_reg: directed self-checking bench for signext_reg.
// Honours SIGNEXT_B_FORMAT_EN when the build defines it.
module tb_signext_reg;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] result;
  logic        imm_valid;

  int total;
  int bad;

  signext_reg dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .result      (result),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction, clock it in, and settle 1 time unit after the edge.
  task automatic drive(input logic [31:0] instr);
    @(negedge clk);
    instruction = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive({8'b10110100, 19'd23, 5'd1});
    drive({11'b11111000010, 9'd23, 12'd1});
    total++;
    if (result !== 64'h0 || imm_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: result=%h valid=%b want result=0 valid=0", result, imm_valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_cb();
    logic [31:0] v [4];
    logic [63:0] e [4];
    v[0] = {8'b10110100, 19'd23, 5'd1};                  e[0] = 64'd23;
    v[1] = {8'b10110100, 19'b1111111111111101001, 5'd1}; e[1] = 64'hFFFF_FFFF_FFFF_FFE9;
    v[2] = {8'b10110101, 19'd23, 5'd31};                 e[2] = 64'd23;
    v[3] = {8'b10110101, 19'h3FFFF, 5'd0};               e[3] = 64'h0000_0000_0003_FFFF;
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      total++;
      if (result !== e[i] || imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL cb[%0d]: result=%h valid=%b want %h valid=1", i, result, imm_valid, e[i]);
      end
    end
  endtask

  task automatic test_d();
    logic [31:0] v [6];
    logic [63:0] e [6];
    v[0] = {11'b11111000010, 9'd23, 12'd1};         e[0] = 64'd23;
    v[1] = {11'b11111000010, 9'b111101001, 12'd1};  e[1] = 64'hFFFF_FFFF_FFFF_FFE9;
    v[2] = {11'b11111000000, 9'd23, 12'd1};         e[2] = 64'd23;
    v[3] = {11'b11111000000, 9'b111101001, 12'd1};  e[3] = 64'hFFFF_FFFF_FFFF_FFE9;
    v[4] = {11'b11111000010, 9'h0FF, 12'hFFF};      e[4] = 64'd255;
    v[5] = {11'b11111000000, 9'h100, 12'h000};      e[5] = 64'hFFFF_FFFF_FFFF_FF00;
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      total++;
      if (result !== e[i] || imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL d[%0d]: result=%h valid=%b want %h valid=1", i, result, imm_valid, e[i]);
      end
    end
  endtask

  task automatic test_addi();
    logic [31:0] v [4];
    logic [63:0] e [4];
    v[0] = {10'b1001000100, 12'd23, 5'd1, 5'd1};            e[0] = 64'd23;
    v[1] = {10'b1001000100, 12'b111111101001, 5'd1, 5'd1};  e[1] = 64'hFFFF_FFFF_FFFF_FFE9;
    v[2] = {10'b1001000100, 12'h7FF, 5'd31, 5'd31};         e[2] = 64'd2047;
    v[3] = {10'b1001000100, 12'h800, 5'd0, 5'd0};           e[3] = 64'hFFFF_FFFF_FFFF_F800;
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      total++;
      if (result !== e[i] || imm_valid !== 1'b1) begin
        bad++;
        $display("FAIL addi[%0d]: result=%h valid=%b want %h valid=1", i, result, imm_valid, e[i]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [31:0] v [3];
    v[0] = {11'b10011000000, 9'd23, 12'd1};
    v[1] = {11'b11111000011, 9'd23, 12'd1};
    v[2] = {10'b1001000101, 12'd23, 10'd0};
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      total++;
      if (result !== 64'h0 || imm_valid !== 1'b0) begin
        bad++;
        $display("FAIL invalid[%0d]: result=%h valid=%b want 0 valid=0", i, result, imm_valid);
      end
    end
  endtask

  task automatic test_b_format();
    logic [31:0] v [2];
    logic [63:0] e [2];
    logic        ev;
    v[0] = {6'b000101, 26'h3FFFFFF};
    v[1] = {6'b000101, 26'd5};
`ifdef SIGNEXT_B_FORMAT_EN
    e[0] = 64'hFFFF_FFFF_FFFF_FFFF; e[1] = 64'd5; ev = 1'b1;
`else
    e[0] = 64'h0;                   e[1] = 64'h0; ev = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      drive(v[i]);
      total++;
      if (result !== e[i] || imm_valid !== ev) begin
        bad++;
        $display("FAIL b[%0d]: result=%h valid=%b want %h valid=%b", i, result, imm_valid, e[i], ev);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 7;
    logic [31:0] v [N];
    logic        r [N];
    logic [63:0] e [N];
    logic        ev [N];
    logic [63:0] prev_e;
    logic        prev_v;
    v[0] = {8'b10110100, 19'd23, 5'd1};                   r[0] = 1'b0; e[0] = 64'd23;                 ev[0] = 1'b1;
    v[1] = {11'b11111000010, 9'b111101001, 12'd1};        r[1] = 1'b0; e[1] = 64'hFFFF_FFFF_FFFF_FFE9; ev[1] = 1'b1;
    v[2] = {10'b1001000100, 12'd100, 10'd0};              r[2] = 1'b1; e[2] = 64'h0;                  ev[2] = 1'b0;
    v[3] = {10'b1001000100, 12'd100, 10'd0};              r[3] = 1'b0; e[3] = 64'd100;                ev[3] = 1'b1;
    v[4] = {11'b10011000000, 9'd23, 12'd1};               r[4] = 1'b0; e[4] = 64'h0;                  ev[4] = 1'b0;
    v[5] = {8'b10110101, 19'b1111111111111101001, 5'd2};  r[5] = 1'b0; e[5] = 64'hFFFF_FFFF_FFFF_FFE9; ev[5] = 1'b1;
    v[6] = {11'b11111000000, 9'd7, 12'd0};                r[6] = 1'b0; e[6] = 64'd7;                  ev[6] = 1'b1;
    prev_e = result;
    prev_v = imm_valid;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      instruction = v[i];
      reset       = r[i];
      #1;
      total++;
      if (result !== prev_e || imm_valid !== prev_v) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: result=%h valid=%b want %h valid=%b", i, result, imm_valid, prev_e, prev_v);
      end
      @(posedge clk);
      #1;
      total++;
      if (result !== e[i] || imm_valid !== ev[i]) begin
        bad++;
        $display("FAIL b2b[%0d]: result=%h valid=%b want %h valid=%b", i, result, imm_valid, e[i], ev[i]);
      end
      prev_e = e[i];
      prev_v = ev[i];
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b1;
    instruction = 32'h0;
    test_reset();
    test_cb();
    test_d();
    test_addi();
    test_invalid();
    test_b_format();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
